// File: rtl/ahb_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_master_if
//  Purpose  : Far-side AHB-Lite master of the AHB2AHB bridge. Takes simple
//             valid/ready requests from the slave front end and issues each
//             one as a SINGLE NONSEQ transfer. The address and data phases
//             are pipelined, so it sustains one transfer per cycle when the
//             bus inserts no wait states. ERROR responses use the two-cycle
//             AHB cancel sequence, and the pending address phase is retried.
//  Ports    : i_clk_ahb, i_rst_ahb (async, active-high)
//             Front end : i_valid, i_rd0_wr1, i_addr, i_wr_data, o_ready,
//                         o_rd_valid, o_rd_data, o_err
//             AHB       : o_htrans, o_haddr, o_hwrite, o_hsize, o_hburst,
//                         o_hwdata, i_hready, i_hresp, i_hrdata
//  Revision : 1.0  initial release
// ============================================================================
module ahb_master_if #(
    parameter int           DATA_WIDTH = 32,
    parameter int           ADDR_WIDTH = 32,
    parameter logic [2:0]   HSIZE      = 3'b010
) (
    input  logic                    i_clk_ahb,
    input  logic                    i_rst_ahb,
    input  logic                    i_valid,
    input  logic                    i_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic                    o_ready,
    output logic                    o_rd_valid,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_err,
    output logic [1:0]              o_htrans,
    output logic [ADDR_WIDTH-1:0]   o_haddr,
    output logic                    o_hwrite,
    output logic [2:0]              o_hsize,
    output logic [2:0]              o_hburst,
    output logic [DATA_WIDTH-1:0]   o_hwdata,
    input  logic                    i_hready,
    input  logic                    i_hresp,
    input  logic [DATA_WIDTH-1:0]   i_hrdata
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } state_t;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_err_start;
    logic                   w_run;
    logic                   w_ready;
    logic                   w_accept;

    // Address-phase slot
    logic                   r_ap_valid;
    logic [ADDR_WIDTH-1:0]  r_ap_addr;
    logic                   r_ap_write;
    logic [DATA_WIDTH-1:0]  r_ap_wdata;
    // Data-phase slot
    logic                   r_dp_valid;
    logic                   r_dp_write;
    logic [DATA_WIDTH-1:0]  r_dp_wdata;
    // Front-end responses
    logic                   r_rd_valid;
    logic [DATA_WIDTH-1:0]  r_rd_data;
    logic                   r_err;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
        if (i_rst_ahb) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state. The first ERROR cycle (hready low) is detected while
    // still in RUN so that HTRANS can be forced to IDLE in that same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_err_start = 1'b0;
        case (r_state)
            S_RUN: begin
                if (r_dp_valid && i_hresp && !i_hready) begin
                    w_err_start = 1'b1;
                    w_state_nxt = S_ERR1;
                end
            end
            S_ERR1: begin
                if (i_hready && i_hresp) begin
                    w_state_nxt = S_ERR2;
                end
            end
            S_ERR2:  w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    assign w_run    = (r_state == S_RUN);
    // The AP slot may be refilled when it is empty or is about to move to DP.
    assign w_ready  = w_run && (!r_ap_valid || i_hready) && !i_rst_ahb;
    assign w_accept = i_valid && w_ready;

    // ------------------------------------------------------------------------
    // Pipeline slots and response pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
        if (i_rst_ahb) begin
            r_ap_valid <= 1'b0;
            r_ap_addr  <= '0;
            r_ap_write <= 1'b0;
            r_ap_wdata <= '0;
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_wdata <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (i_hready) begin
                        if (r_dp_valid && !r_dp_write && !i_hresp) begin
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= i_hrdata;
                        end
                        r_dp_valid <= r_ap_valid;
                        if (r_ap_valid) begin
                            r_dp_write <= r_ap_write;
                            r_dp_wdata <= r_ap_wdata;
                        end
                    end
                    // Acceptance while hready is low only happens with AP empty,
                    // so a stalled, occupied AP is never overwritten.
                    if (w_accept) begin
                        r_ap_valid <= 1'b1;
                        r_ap_addr  <= i_addr;
                        r_ap_write <= i_rd0_wr1;
                        r_ap_wdata <= i_wr_data;
                    end else if (i_hready) begin
                        r_ap_valid <= 1'b0;
                    end
                end
                S_ERR1: begin
                    // Second ERROR cycle: retire DP only. AP was cancelled
                    // on the bus (IDLE) and is kept for re-issue.
                    if (i_hready && i_hresp) begin
                        r_dp_valid <= 1'b0;
                        r_err      <= 1'b1;
                        if (!r_dp_write) begin
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_htrans   = (w_run && r_ap_valid && !w_err_start) ? c_HTRANS_NONSEQ
                                                              : c_HTRANS_IDLE;
    assign o_haddr    = r_ap_addr;
    assign o_hwrite   = r_ap_write;
    assign o_hsize    = HSIZE;
    assign o_hburst   = 3'b000;
    assign o_hwdata   = r_dp_wdata;
    assign o_ready    = w_ready;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_err      = r_err;

endmodule
`default_nettype wire
